// File: rtl/pc_sched_pkg.sv
// Shared fetch-scheduler definitions: FSM encodings, PC geometry defaults,
// enable levels and the redirect-source priority encoding.
package pc_sched_pkg;

  localparam int unsigned PC_LENGTH = 32;
  localparam int unsigned PC_STEP   = 4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StStall,
    StPend
  } state_e;

  // Encoded so that a larger value is a higher-priority redirect source.
  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcJ    = 2'd1,
    SrcBr   = 2'd2,
    SrcExc  = 2'd3
  } redir_src_e;

endpackage

// File: rtl/pc_sched_if.sv
// Fetch-scheduler bus: hazard/redirect requests in, fetch address out.
// alignErr exists only when PC_SCHED_ALIGN_CHK_EN is defined.
interface pc_sched_if #(
  parameter int unsigned PC_LENGTH = pc_sched_pkg::PC_LENGTH
);

  logic                 stall;
  logic                 excCe;
  logic [PC_LENGTH-1:0] excAddr;
  logic                 brCe;
  logic [PC_LENGTH-1:0] brAddr;
  logic                 jCe;
  logic [PC_LENGTH-1:0] jAddr;
  logic [PC_LENGTH-1:0] pc;
  logic                 romCe;
  logic                 flush;
`ifdef PC_SCHED_ALIGN_CHK_EN
  logic                 alignErr;

  modport master (
    output stall, excCe, excAddr, brCe, brAddr, jCe, jAddr,
    input  pc, romCe, flush, alignErr
  );

  modport slave (
    input  stall, excCe, excAddr, brCe, brAddr, jCe, jAddr,
    output pc, romCe, flush, alignErr
  );
`else
  modport master (
    output stall, excCe, excAddr, brCe, brAddr, jCe, jAddr,
    input  pc, romCe, flush
  );

  modport slave (
    input  stall, excCe, excAddr, brCe, brAddr, jCe, jAddr,
    output pc, romCe, flush
  );
`endif

endinterface

// File: rtl/pc_redir_pri.sv
// Combinational redirect arbiter: exception > branch > jump; losers dropped.
module pc_redir_pri #(
  parameter int unsigned PC_LENGTH = 32
) (
  input  logic                 excCe,
  input  logic [PC_LENGTH-1:0] excAddr,
  input  logic                 brCe,
  input  logic [PC_LENGTH-1:0] brAddr,
  input  logic                 jCe,
  input  logic [PC_LENGTH-1:0] jAddr,
  output logic                 valid,
  output logic [PC_LENGTH-1:0] target
);
  import pc_sched_pkg::*;

  redir_src_e src;

  // Pick the highest-priority active request.
  always_comb begin
    src = SrcNone;
    if (excCe) begin
      src = SrcExc;
    end else if (brCe) begin
      src = SrcBr;
    end else if (jCe) begin
      src = SrcJ;
    end
  end

  // Route the winner's target.
  always_comb begin
    valid  = (src != SrcNone);
    target = '0;
    unique case (src)
      SrcExc:  target = excAddr;
      SrcBr:   target = brAddr;
      SrcJ:    target = jAddr;
      SrcNone: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_sched.sv
// PC scheduler: sequential fetch, stall freeze, prioritised redirects with a
// pending target held across stalls. Optional misaligned-target rejection is
// built when PC_SCHED_ALIGN_CHK_EN is defined.
module pc_sched #(
  parameter int unsigned          PC_LENGTH = pc_sched_pkg::PC_LENGTH,
  parameter int unsigned          PC_STEP   = pc_sched_pkg::PC_STEP,
  parameter logic [PC_LENGTH-1:0] RESET_PC  = '0
) (
  input logic       clk,
  input logic       rst,
  pc_sched_if.slave bus
);
  import pc_sched_pkg::*;

  localparam logic [PC_LENGTH-1:0] Step = PC_LENGTH'(PC_STEP);

  state_e               state;
  logic [PC_LENGTH-1:0] pend_addr;
  logic                 win_valid;
  logic [PC_LENGTH-1:0] win_target;
  logic                 redir;

  pc_redir_pri #(
    .PC_LENGTH (PC_LENGTH)
  ) u_redir_pri (
    .excCe   (bus.excCe),
    .excAddr (bus.excAddr),
    .brCe    (bus.brCe),
    .brAddr  (bus.brAddr),
    .jCe     (bus.jCe),
    .jAddr   (bus.jAddr),
    .valid   (win_valid),
    .target  (win_target)
  );

`ifdef PC_SCHED_ALIGN_CHK_EN
  logic misalign;

  // A misaligned winner is treated as no redirect at all.
  always_comb begin
    misalign = win_valid && ((win_target % Step) != '0);
    redir    = win_valid && !misalign;
  end
`else
  // Every winning target is accepted as-is.
  always_comb begin
    redir = win_valid;
  end
`endif

  // Fetch FSM with registered pc/romCe/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StBoot;
      bus.pc      <= RESET_PC;
      bus.romCe   <= DISABLE;
      bus.flush   <= DISABLE;
      pend_addr   <= '0;
`ifdef PC_SCHED_ALIGN_CHK_EN
      bus.alignErr <= DISABLE;
`endif
    end else begin
      bus.flush <= DISABLE;
      unique case (state)
        StBoot: begin
          state     <= StRun;
          bus.romCe <= ENABLE;
        end
        StRun, StStall: begin
          if (redir && bus.stall) begin
            pend_addr <= win_target;
            bus.flush <= ENABLE;
            state     <= StPend;
          end else if (redir) begin
            bus.pc    <= win_target;
            bus.flush <= ENABLE;
            state     <= StRun;
          end else if (bus.stall) begin
            state <= StStall;
          end else begin
            bus.pc <= bus.pc + Step;
            state  <= StRun;
          end
        end
        StPend: begin
          if (bus.stall) begin
            // A newer redirect replaces the held target.
            if (redir) begin
              pend_addr <= win_target;
              bus.flush <= ENABLE;
            end
          end else begin
            bus.pc    <= redir ? win_target : pend_addr;
            bus.flush <= redir;
            state     <= StRun;
          end
        end
        default: state <= StBoot;
      endcase
`ifdef PC_SCHED_ALIGN_CHK_EN
      // Inputs are ignored while booting.
      bus.alignErr <= misalign && (state != StBoot);
`endif
    end
  end

endmodule

// File: tb/tb_pc_sched.sv
// Directed scoreboard bench for pc_sched. Each step drives one cycle of
// inputs and queues the outputs expected after the following rising edge;
// a monitor pops and compares one entry per cycle.
module tb_pc_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_sched_if #(.PC_LENGTH(32)) bus ();

  pc_sched #(
    .PC_LENGTH (32),
    .PC_STEP   (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        rom;
    logic        flush;
    logic        aerr;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  logic  aerr_now;
  obs_t  mon_exp;
  obs_t  mon_act;
  string mon_name;

`ifdef PC_SCHED_ALIGN_CHK_EN
  assign aerr_now = bus.alignErr;
`else
  assign aerr_now = 1'b0;
`endif

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = '{pc: bus.pc, rom: bus.romCe, flush: bus.flush, aerr: aerr_now};
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL %s: got pc=%h romCe=%b flush=%b alignErr=%b, required pc=%h romCe=%b flush=%b alignErr=%b",
                   mon_name, mon_act.pc, mon_act.rom, mon_act.flush, mon_act.aerr,
                   mon_exp.pc, mon_exp.rom, mon_exp.flush, mon_exp.aerr);
        end
      end
    end
  end

  task automatic step(input logic r, input logic s,
                      input logic ec, input logic [31:0] ea,
                      input logic bc, input logic [31:0] ba,
                      input logic jc, input logic [31:0] ja,
                      input logic [31:0] epc, input logic erom,
                      input logic eflush, input logic eaerr, input string name);
    @(negedge clk);
    rst         = r;
    bus.stall   = s;
    bus.excCe   = ec;
    bus.excAddr = ea;
    bus.brCe    = bc;
    bus.brAddr  = ba;
    bus.jCe     = jc;
    bus.jAddr   = ja;
    exp_q.push_back('{pc: epc, rom: erom, flush: eflush, aerr: eaerr});
    name_q.push_back(name);
  endtask

  task automatic idle(input logic [31:0] epc, input logic eflush, input string name);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 1'b1, eflush, 1'b0, name);
  endtask

  task automatic hold(input logic ec, input logic [31:0] ea, input logic bc,
                      input logic [31:0] ba, input logic jc, input logic [31:0] ja,
                      input logic [31:0] epc, input logic eflush, input string name);
    step(1'b0, 1'b1, ec, ea, bc, ba, jc, ja, epc, 1'b1, eflush, 1'b0, name);
  endtask

  task automatic go(input logic ec, input logic [31:0] ea, input logic bc,
                    input logic [31:0] ba, input logic jc, input logic [31:0] ja,
                    input logic [31:0] epc, input logic eflush, input string name);
    step(1'b0, 1'b0, ec, ea, bc, ba, jc, ja, epc, 1'b1, eflush, 1'b0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.stall = 1'b0;
    bus.excCe = 1'b0; bus.excAddr = '0;
    bus.brCe  = 1'b0; bus.brAddr  = '0;
    bus.jCe   = 1'b0; bus.jAddr   = '0;

    // Reset with every request active: reset wins.
    step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h20,
         32'h0, 1'b0, 1'b0, 1'b0, "reset_boot");
    idle(32'h0, 1'b0, "boot_to_run");
    idle(32'h4, 1'b0, "seq_4");
    idle(32'h8, 1'b0, "seq_8");
    idle(32'hC, 1'b0, "seq_c");
    idle(32'h10, 1'b0, "seq_10");

    // Simultaneous redirects: exception wins, single flush pulse.
    go(1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h20, 32'h80, 1'b1, "prio_exc");
    idle(32'h84, 1'b0, "prio_after");

    // Stall window with a branch in the second stall cycle.
    go(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h20, 1'b1, "jump_20");
    hold(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0, "stall_1");
    hold(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h20, 1'b1, "stall_2_br");
    hold(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0, "stall_3");
    idle(32'h100, 1'b0, "pend_release");
    idle(32'h104, 1'b0, "pend_after");

    // Plain stall then release.
    hold(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h104, 1'b0, "plain_stall");
    idle(32'h108, 1'b0, "stall_release");

    // Pending target superseded by a redirect in the release cycle.
    hold(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 32'h108, 1'b1, "pend_exc");
    go(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400, 32'h400, 1'b1, "pend_new_redir");
    idle(32'h404, 1'b0, "pend_new_after");

    // Pending target overwritten while still stalled.
    hold(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h404, 1'b1, "pend_br");
    hold(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h600, 32'h404, 1'b1, "pend_overwrite");
    idle(32'h600, 1'b0, "overwrite_release");
    idle(32'h604, 1'b0, "overwrite_after");

    // Redirect arriving in the cycle a stall drops.
    hold(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h604, 1'b0, "stall_again");
    go(1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h0, 32'h700, 1'b1, "stall_drop_br");
    idle(32'h704, 1'b0, "stall_drop_after");

    // Misaligned jump target.
    go(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h30, 32'h30, 1'b1, "jump_30");
`ifdef PC_SCHED_ALIGN_CHK_EN
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h22,
         32'h34, 1'b1, 1'b0, 1'b1, "misalign_drop");
    idle(32'h38, 1'b0, "misalign_after");
`else
    go(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h22, 32'h22, 1'b1, "unaligned_take");
    idle(32'h26, 1'b0, "unaligned_after");
`endif

    // Wrap at the top of the address space.
    go(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, "jump_top");
    idle(32'h0, 1'b0, "wrap_0");
    idle(32'h4, 1'b0, "wrap_4");

    // Reset during PEND discards the pending target.
    hold(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1, "pend_200");
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         32'h0, 1'b0, 1'b0, 1'b0, "pend_reset");
    idle(32'h0, 1'b0, "pend_reset_run");
    idle(32'h4, 1'b0, "pend_lost_4");
    idle(32'h8, 1'b0, "pend_lost_8");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
